// File: rtl/tile_map_pkg.sv
// Shared types and level-1 layout for the tile map.
// The sell option is enabled by defining TILE_MAP_SELL_EN.
package tile_map_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PATH    = 2'd1,
    TOWER   = 2'd2,
    BLOCKED = 2'd3
  } tile_t;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_OOB      = 2'd1,
    ERR_OCCUPIED = 2'd2,
    ERR_FULL     = 2'd3
  } place_err_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_RESP   = 2'd3
  } place_state_t;

  localparam int DEF_COLS = 20;
  localparam int DEF_ROWS = 15;

  // Indexed [row][col]; bit 'col' of each row word. Path runs down column 8
  // to row 7, then right along row 7 to the last column.
  localparam logic [DEF_ROWS-1:0][DEF_COLS-1:0] DEFAULT_PATH = {
    20'h00000,  // row 14
    20'h00000,  // row 13
    20'h00000,  // row 12
    20'h00000,  // row 11
    20'h00000,  // row 10
    20'h00000,  // row 9
    20'h00000,  // row 8
    20'hFFF00,  // row 7
    20'h00100,  // row 6
    20'h00100,  // row 5
    20'h00100,  // row 4
    20'h00100,  // row 3
    20'h00100,  // row 2
    20'h00100,  // row 1
    20'h00100   // row 0
  };

endpackage

// File: rtl/tile_map_ram_tile_addr_decode.sv
// Pixel coordinate pair to tile column/row with a full-width bounds check.
module tile_addr_decode #(
  parameter int TILE_SHIFT = 5,
  parameter int COLS       = 20,
  parameter int ROWS       = 15,
  parameter int CW         = $clog2(COLS),
  parameter int RW         = $clog2(ROWS)
) (
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          in_bounds
);

  localparam int FW = 10 - TILE_SHIFT;

  logic [FW-1:0] col_full;
  logic [FW-1:0] row_full;

  assign col_full  = FW'(x >> TILE_SHIFT);
  assign row_full  = FW'(y >> TILE_SHIFT);
  assign in_bounds = (32'(col_full) < COLS) && (32'(row_full) < ROWS);
  assign col       = CW'(col_full);
  assign row       = RW'(row_full);

endmodule

// File: rtl/tile_map_ram.sv
// Writable tile map with pixel/mouse lookup ports and a tower placement FSM.
// Define TILE_MAP_SELL_EN to add the place_op input (0=place, 1=sell).
module tile_map_ram
  import tile_map_pkg::*;
#(
  parameter int TILE_SHIFT = 5,
  parameter int COLS       = DEF_COLS,
  parameter int ROWS       = DEF_ROWS,
  parameter int TYPE_W     = 2,
  parameter int MAX_TOWERS = 16,
  parameter int CNTW       = $clog2(MAX_TOWERS+1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  output logic [TYPE_W-1:0] pix_tile,
  input  logic [9:0]        mouse_x,
  input  logic [9:0]        mouse_y,
  output logic [TYPE_W-1:0] mouse_tile,
  input  logic              place_req,
  input  logic [9:0]        place_x,
  input  logic [9:0]        place_y,
`ifdef TILE_MAP_SELL_EN
  input  logic              place_op,
`endif
  output logic              place_busy,
  output logic              place_done,
  output logic              place_ok,
  output logic [1:0]        place_err,
  output logic [CNTW-1:0]   tower_count
);

  // state     | meaning
  // ST_IDLE   | waiting for place_req, latches coordinates
  // ST_CHECK  | evaluates legality, registers error code
  // ST_COMMIT | writes the tile and updates tower_count when legal
  // ST_RESP   | one-cycle place_done with ok/err

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic [TYPE_W-1:0] map [ROWS][COLS];

  logic [CW-1:0] pix_col, mouse_col, lat_col;
  logic [RW-1:0] pix_row, mouse_row, lat_row;
  logic          pix_in, mouse_in, lat_in;

  place_state_t      state, state_d;
  place_err_t        err_q, chk_err;
  logic [9:0]        lat_x, lat_y;
  logic              sell;
  logic              commit_ok;
  logic [TYPE_W-1:0] cur_tile;
  logic [TYPE_W-1:0] wr_val;

  tile_addr_decode #(.TILE_SHIFT(TILE_SHIFT), .COLS(COLS), .ROWS(ROWS)) u_dec_pix (
    .x(pix_x), .y(pix_y), .col(pix_col), .row(pix_row), .in_bounds(pix_in)
  );

  tile_addr_decode #(.TILE_SHIFT(TILE_SHIFT), .COLS(COLS), .ROWS(ROWS)) u_dec_mouse (
    .x(mouse_x), .y(mouse_y), .col(mouse_col), .row(mouse_row), .in_bounds(mouse_in)
  );

  tile_addr_decode #(.TILE_SHIFT(TILE_SHIFT), .COLS(COLS), .ROWS(ROWS)) u_dec_place (
    .x(lat_x), .y(lat_y), .col(lat_col), .row(lat_row), .in_bounds(lat_in)
  );

`ifdef TILE_MAP_SELL_EN
  logic lat_op;
  assign sell = lat_op;
`else
  assign sell = 1'b0;
`endif

  assign commit_ok = (state == ST_COMMIT) && (err_q == ERR_OK);
  assign wr_val    = sell ? TYPE_W'(EMPTY) : TYPE_W'(TOWER);
  assign cur_tile  = map[lat_row][lat_col];

  // One register per tile so reset can reload the whole level in one edge.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam bit IS_PATH = (r < DEF_ROWS && c < DEF_COLS) ?
                               DEFAULT_PATH[r % DEF_ROWS][c % DEF_COLS] : 1'b0;
      logic [TYPE_W-1:0] cell_q;
      always_ff @(posedge Clk) begin
        if (!Reset)
          cell_q <= IS_PATH ? TYPE_W'(PATH) : TYPE_W'(EMPTY);
        else if (commit_ok && lat_row == RW'(r) && lat_col == CW'(c))
          cell_q <= wr_val;
      end
      assign map[r][c] = cell_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pix_tile   <= '0;
      mouse_tile <= '0;
    end else begin
      pix_tile   <= pix_in   ? map[pix_row][pix_col]     : TYPE_W'(BLOCKED);
      mouse_tile <= mouse_in ? map[mouse_row][mouse_col] : TYPE_W'(BLOCKED);
    end
  end

  always_comb begin
    state_d = state;
    chk_err = ERR_OK;
    if (!lat_in)
      chk_err = ERR_OOB;
    else if (sell ? (cur_tile != TYPE_W'(TOWER)) : (cur_tile != TYPE_W'(EMPTY)))
      chk_err = ERR_OCCUPIED;
    else if (!sell && tower_count == CNTW'(MAX_TOWERS))
      chk_err = ERR_FULL;
    case (state)
      ST_IDLE:   if (place_req) state_d = ST_CHECK;
      ST_CHECK:  state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state       <= ST_IDLE;
      err_q       <= ERR_OK;
      lat_x       <= '0;
      lat_y       <= '0;
      tower_count <= '0;
`ifdef TILE_MAP_SELL_EN
      lat_op      <= 1'b0;
`endif
    end else begin
      state <= state_d;
      if (state == ST_IDLE && place_req) begin
        lat_x  <= place_x;
        lat_y  <= place_y;
`ifdef TILE_MAP_SELL_EN
        lat_op <= place_op;
`endif
      end
      if (state == ST_CHECK)
        err_q <= chk_err;
      if (commit_ok)
        tower_count <= sell ? tower_count - 1'b1 : tower_count + 1'b1;
    end
  end

  assign place_busy = (state != ST_IDLE);
  assign place_done = (state == ST_RESP);
  assign place_ok   = place_done && (err_q == ERR_OK);
  assign place_err  = place_done ? err_q : ERR_OK;

endmodule

// File: doc/tile_map_ram.md
Name: tile_map_ram

Overview:
- Writable, parametrised tile map for the playfield: the grid is COLS x ROWS tiles of 2^TILE_SHIFT pixels each, and every tile holds a TYPE_W-bit tile type.
- Provides two registered lookup ports: one for the VGA pixel scan and one for the mouse cursor.
- Provides a request/done placement FSM that lets game logic drop a tower on a free tile. Occupied, out-of-bounds and over-limit placements are rejected with a reason code.
- Sits between the color mapper/mouse logic and the tower-placement controller.

Parameters:
- TILE_SHIFT, 5: log2 of tile edge in pixels.
- COLS, 20: tiles per row.
- ROWS, 15: tile rows.
- TYPE_W, 2: tile type width.
- MAX_TOWERS, 16: maximum number of TOWER tiles.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-low reset.
- pix_x, pix_y  in  10 each  pixel scan coordinates.
- pix_tile  out  TYPE_W  tile type at (pix_x, pix_y), registered.
- mouse_x, mouse_y  in  10 each  cursor coordinates.
- mouse_tile  out  TYPE_W  tile type under the cursor, registered.
- place_req  in  1  request pulse/level, sampled in IDLE only.
- place_x, place_y  in  10 each  pixel coordinates of the request.
- place_busy  out  1  FSM not in IDLE.
- place_done  out  1  one-cycle completion pulse.
- place_ok  out  1  valid with place_done; 1 means the map was modified.
- place_err  out  2  valid with place_done: 0 OK, 1 OOB, 2 OCCUPIED, 3 FULL.
- tower_count  out  $clog2(MAX_TOWERS+1)  number of TOWER tiles.

Behaviour:
- Tile types: EMPTY=0, PATH=1, TOWER=2, BLOCKED=3. Tile index is (coordinate >> TILE_SHIFT).
  - The tile is in bounds iff col < COLS and row < ROWS.
  - Compare at full width; do not truncate before the compare.
- Reset (Reset==0 at a Clk edge):
  - Every tile loads PATH where DEFAULT_PATH[row][col]==1, otherwise EMPTY.
  - tower_count=0, FSM=IDLE.
  - pix_tile=mouse_tile=0; place_busy=place_done=place_ok=0; place_err=0.
- Lookup ports:
  - One-cycle latency; outputs update every cycle, independent of the FSM.
  - An out-of-bounds coordinate returns BLOCKED.
  - A tile written in COMMIT is visible on the lookup outputs for coordinates presented in the cycle after COMMIT.
- FSM states and transitions: IDLE -> CHECK -> COMMIT -> RESP -> IDLE.
  - IDLE: if place_req==1, latch place_x/place_y and go to CHECK. place_busy=0.
  - CHECK: compute the error code in priority order OOB > OCCUPIED (tile != EMPTY) > FULL (tower_count==MAX_TOWERS); register it.
  - COMMIT: if the code is OK, write TOWER and increment tower_count; otherwise write nothing.
  - RESP: place_done=1, place_ok=(err==0), place_err=code; return to IDLE.
- Timing:
  - place_done is asserted exactly 3 cycles after the IDLE cycle that sampled place_req, for both accepted and rejected requests.
  - place_busy=1 in CHECK, COMMIT and RESP.
  - place_req is ignored while busy; a held req starts a new transaction in the IDLE cycle following RESP.
- tower_count never exceeds MAX_TOWERS; it never wraps.
- Reset mid-transaction: the FSM aborts immediately, no place_done is issued, and the map reloads from DEFAULT_PATH, discarding any tower written earlier.

Optional Feature:
- Macro: TILE_MAP_SELL_EN.
- Defined: adds input place_op (1 bit; 0=place, 1=sell), latched with the coordinates.
  - Sell legality: OOB > OCCUPIED (here meaning tile != TOWER).
  - On a legal sell, COMMIT writes EMPTY and decrements tower_count. FULL never applies to sell.
- Undefined: no place_op port; every request is a placement. Timing is identical in both builds.

Decomposition:
- Package tile_map_pkg holds:
  - tile_t enum (EMPTY/PATH/TOWER/BLOCKED);
  - place_err_t enum;
  - fsm state enum;
  - COLS/ROWS defaults;
  - DEFAULT_PATH, a [ROWS][COLS] bit array holding the level-1 path.
- One sub-module, tile_addr_decode: pixel coordinate pair -> col, row, in_bounds. It is instantiated three times (pixel, mouse, placement).

Test Plan:
- Reset, then pix=(256,0) (tile 8,0, a PATH tile) and pix=(0,448) (tile 0,14) -> pix_tile=PATH, then EMPTY, each one cycle later. pix_x=640 -> BLOCKED.
- place_req at (10,10) -> done on cycle 3, ok=1, err=0; tower_count 0->1; mouse at (31,31) returns TOWER.
- Repeat (10,10) -> ok=0, err=OCCUPIED. Place at (256,0) -> err=OCCUPIED. Place at (700,10) -> err=OOB. tower_count unchanged in all three.
- Place 16 distinct EMPTY tiles, then a 17th -> err=FULL, tower_count=16. Hold place_req high -> transactions spaced exactly 4 cycles apart.
- Drop Reset during COMMIT of a legal place -> no done pulse, tower_count=0, tile reads EMPTY.
- With TILE_MAP_SELL_EN: sell (10,10) after placing it -> ok=1, count decrements, tile reads EMPTY. Sell (256,0) -> err=OCCUPIED.
